// File: rtl/dma_pkg.sv
// Shared types and helpers for the DMA channel arbiter.
package dma_pkg;

    localparam int NUM_CHANNELS = 4;
    localparam int CHAN_W       = $clog2(NUM_CHANNELS);

    typedef logic [CHAN_W-1:0] chan_idx_t;

    typedef enum logic [1:0] {
        ARB_IDLE      = 2'd0,
        ARB_HOLD_WAIT = 2'd1,
        ARB_GRANT     = 2'd2
    } arb_state_t;

    // One-hot decode of a channel index.
    function automatic logic [NUM_CHANNELS-1:0] chan_onehot(input chan_idx_t idx);
        logic [NUM_CHANNELS-1:0] vec;
        vec      = {NUM_CHANNELS{1'b0}};
        vec[idx] = 1'b1;
        return vec;
    endfunction

    // Circular right rotate: bit i of the result is bit (i+amt) mod N of vec.
    function automatic logic [NUM_CHANNELS-1:0] rotate_right(
        input logic [NUM_CHANNELS-1:0] vec,
        input chan_idx_t               amt
    );
        logic [2*NUM_CHANNELS-1:0] dbl;
        dbl = {vec, vec};
        dbl = dbl >> amt;
        return dbl[NUM_CHANNELS-1:0];
    endfunction

endpackage

// File: rtl/dma_priority_arbiter_if.sv
// Request/acknowledge bundle between the request pins, the CPU hold
// handshake, timing-and-control and the channel arbiter.
interface dma_priority_arbiter_if;
    import dma_pkg::*;

    logic [NUM_CHANNELS-1:0] DREQ;
    logic [NUM_CHANNELS-1:0] maskReg;
    logic                    rotatingPriority;
    logic                    HLDA;
    logic                    serviceDone;
    logic                    HRQ;
    logic [NUM_CHANNELS-1:0] DACK;
    chan_idx_t               activeChannel;
    logic                    grantValid;

    // Requesting side: drives requests, mask, mode, hold-ack and end of service.
    modport master (
        output DREQ, maskReg, rotatingPriority, HLDA, serviceDone,
        input  HRQ, DACK, activeChannel, grantValid
    );

    // Arbiter side.
    modport slave (
        input  DREQ, maskReg, rotatingPriority, HLDA, serviceDone,
        output HRQ, DACK, activeChannel, grantValid
    );

endinterface

// File: rtl/dma_priority_resolver.sv
// Combinational winner selection: rotate the request vector so the search
// starts at the highest-priority channel, find the first set bit, then map
// the offset back to an absolute channel number.
module dma_priority_resolver
    import dma_pkg::*;
(
    input  logic [NUM_CHANNELS-1:0] eff_req,
    input  logic                    rotating_priority,
    input  chan_idx_t               last_serviced,
    output chan_idx_t               winner,
    output logic                    any_req
);

    chan_idx_t               start_s;
    logic [NUM_CHANNELS-1:0] rotated_s;
    chan_idx_t               offset_s;

    // Rotate, find-first, un-rotate; the modulo wrap comes from the index width.
    always_comb begin
        start_s   = 2'd0;
        rotated_s = 4'b0000;
        offset_s  = 2'd0;
        if (rotating_priority) begin
            start_s = last_serviced + 2'd1;
        end else begin
            start_s = 2'd0;
        end
        rotated_s = rotate_right(eff_req, start_s);
        // Scan from the top down so the lowest set offset is left standing.
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            if (rotated_s[i]) begin
                offset_s = chan_idx_t'(i);
            end else begin
                offset_s = offset_s;
            end
        end
        winner  = start_s + offset_s;
        any_req = |eff_req;
    end

endmodule

// File: rtl/dma_priority_arbiter.sv
// Channel arbiter for the 4-channel DMA controller: resolves masked requests
// under fixed or rotating priority, runs the HRQ/HLDA hold handshake and
// keeps a one-hot DACK on the winner until end of service or bus loss.
module dma_priority_arbiter
    import dma_pkg::*;
(
    input  logic                   CLK,
    input  logic                   RESET_N,
    dma_priority_arbiter_if.slave  bus
);

    arb_state_t              state_r;
    logic                    hrq_r;
    logic [NUM_CHANNELS-1:0] dack_r;
    chan_idx_t               active_r;
    logic                    grant_valid_r;
    chan_idx_t               last_serviced_r;

    logic [NUM_CHANNELS-1:0] eff_req_s;
    chan_idx_t               winner_s;
    logic                    any_req_s;

    assign eff_req_s = bus.DREQ & ~bus.maskReg;

    dma_priority_resolver u_resolver (
        .eff_req           (eff_req_s),
        .rotating_priority (bus.rotatingPriority),
        .last_serviced     (last_serviced_r),
        .winner            (winner_s),
        .any_req           (any_req_s)
    );

    // Arbitration FSM; all outputs and the priority history are registered here.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r         <= ARB_IDLE;
            hrq_r           <= 1'b0;
            dack_r          <= 4'b0000;
            active_r        <= 2'd0;
            grant_valid_r   <= 1'b0;
            last_serviced_r <= 2'd3;
        end else begin
            case (state_r)
                ARB_IDLE: begin
                    dack_r        <= 4'b0000;
                    grant_valid_r <= 1'b0;
                    if (any_req_s) begin
                        state_r  <= ARB_HOLD_WAIT;
                        hrq_r    <= 1'b1;
                        active_r <= winner_s;
                    end else begin
                        state_r  <= ARB_IDLE;
                        hrq_r    <= 1'b0;
                    end
                end

                ARB_HOLD_WAIT: begin
                    if (!any_req_s) begin
                        // Requests withdrawn before the bus was handed over.
                        state_r       <= ARB_IDLE;
                        hrq_r         <= 1'b0;
                        dack_r        <= 4'b0000;
                        grant_valid_r <= 1'b0;
                    end else if (bus.HLDA) begin
                        state_r       <= ARB_GRANT;
                        hrq_r         <= 1'b1;
                        active_r      <= winner_s;
                        dack_r        <= chan_onehot(winner_s);
                        grant_valid_r <= 1'b1;
                    end else begin
                        // Keep tracking the winner while the CPU is still busy.
                        state_r       <= ARB_HOLD_WAIT;
                        hrq_r         <= 1'b1;
                        active_r      <= winner_s;
                        dack_r        <= 4'b0000;
                        grant_valid_r <= 1'b0;
                    end
                end

                ARB_GRANT: begin
                    if (bus.serviceDone) begin
                        // Completion wins over a simultaneous bus loss.
                        state_r         <= ARB_IDLE;
                        hrq_r           <= 1'b0;
                        dack_r          <= 4'b0000;
                        grant_valid_r   <= 1'b0;
                        last_serviced_r <= active_r;
                    end else if (!bus.HLDA) begin
                        // Bus lost: abandon the grant, priority history untouched.
                        state_r         <= ARB_IDLE;
                        hrq_r           <= 1'b0;
                        dack_r          <= 4'b0000;
                        grant_valid_r   <= 1'b0;
                    end else begin
                        // Grant is held regardless of DREQ/mask changes.
                        state_r         <= ARB_GRANT;
                    end
                end

                default: begin
                    state_r       <= ARB_IDLE;
                    hrq_r         <= 1'b0;
                    dack_r        <= 4'b0000;
                    grant_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.HRQ           = hrq_r;
    assign bus.DACK          = dack_r;
    assign bus.activeChannel = active_r;
    assign bus.grantValid    = grant_valid_r;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Directed plus randomized bench for the DMA channel arbiter, checked against
// a cycle model written from the arbitration rules.
module tb_dma_priority_arbiter;
    import dma_pkg::*;

    logic CLK;
    logic RESET_N;
    int   checks;
    int   failures;

    dma_priority_arbiter_if bus ();

    dma_priority_arbiter dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model state: phase 0 idle, 1 waiting for hold-ack, 2 granted.
    int         m_phase;
    logic       m_hrq;
    logic [3:0] m_dack;
    logic [1:0] m_active;
    logic       m_gv;
    logic [1:0] m_last;

    function automatic logic [1:0] pick(input logic [3:0] eff, input logic rot, input logic [1:0] last);
        int start;
        start = rot ? ((int'(last) + 1) % 4) : 0;
        for (int k = 0; k < 4; k++) begin
            int ch;
            ch = (start + k) % 4;
            if (eff[ch]) return 2'(ch);
        end
        return 2'd0;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase  = 0;
        m_hrq    = 1'b0;
        m_dack   = 4'b0000;
        m_active = 2'd0;
        m_gv     = 1'b0;
        m_last   = 2'd3;
    endtask

    task automatic model_step();
        logic [3:0] eff;
        logic [1:0] w;
        eff = bus.DREQ & ~bus.maskReg;
        w   = pick(eff, bus.rotatingPriority, m_last);
        case (m_phase)
            0: if (eff != 4'b0000) begin
                m_phase = 1; m_hrq = 1'b1; m_active = w;
            end
            1: if (eff == 4'b0000) begin
                m_phase = 0; m_hrq = 1'b0;
            end else if (bus.HLDA) begin
                m_phase = 2; m_active = w; m_dack = 4'b0001 << w; m_gv = 1'b1;
            end else begin
                m_active = w;
            end
            2: if (bus.serviceDone) begin
                m_last = m_active;
                m_phase = 0; m_hrq = 1'b0; m_dack = 4'b0000; m_gv = 1'b0;
            end else if (!bus.HLDA) begin
                m_phase = 0; m_hrq = 1'b0; m_dack = 4'b0000; m_gv = 1'b0;
            end
            default: m_phase = 0;
        endcase
    endtask

    task automatic compare_model();
        check("hrq", {7'd0, bus.HRQ}, {7'd0, m_hrq});
        check("dack", {4'd0, bus.DACK}, {4'd0, m_dack});
        check("grant_valid", {7'd0, bus.grantValid}, {7'd0, m_gv});
        if (m_hrq) begin
            check("active_channel", {6'd0, bus.activeChannel}, {6'd0, m_active});
        end
        check("dack_onehot", {7'd0, ($countones(bus.DACK) <= 1)}, 8'd1);
    endtask

    // One clock: advance the model on the inputs the DUT will sample, then compare.
    task automatic cycle();
        model_step();
        @(posedge CLK);
        #1;
        compare_model();
    endtask

    task automatic reset_pulse(input string tag);
        RESET_N = 1'b0;
        #1;
        model_reset();
        check({tag, "_hrq"}, {7'd0, bus.HRQ}, 8'd0);
        check({tag, "_dack"}, {4'd0, bus.DACK}, 8'd0);
        check({tag, "_gv"}, {7'd0, bus.grantValid}, 8'd0);
        check({tag, "_active"}, {6'd0, bus.activeChannel}, 8'd0);
        @(negedge CLK);
        RESET_N = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        model_reset();
        RESET_N              = 1'b0;
        bus.DREQ             = 4'b0000;
        bus.maskReg          = 4'b0000;
        bus.rotatingPriority = 1'b0;
        bus.HLDA             = 1'b0;
        bus.serviceDone      = 1'b0;
        #2;
        check("reset_hrq", {7'd0, bus.HRQ}, 8'd0);
        check("reset_dack", {4'd0, bus.DACK}, 8'd0);
        check("reset_gv", {7'd0, bus.grantValid}, 8'd0);
        check("reset_active", {6'd0, bus.activeChannel}, 8'd0);
        @(negedge CLK);
        RESET_N = 1'b1;
        cycle();

        // Fixed priority, ch1 and ch2 requesting.
        bus.DREQ = 4'b0110;
        cycle();
        check("fixed_hrq_rise", {7'd0, bus.HRQ}, 8'd1);
        cycle();
        cycle();
        bus.HLDA = 1'b1;
        cycle();
        check("fixed_dack", {4'd0, bus.DACK}, 8'h02);
        check("fixed_active", {6'd0, bus.activeChannel}, 8'd1);
        cycle();
        bus.serviceDone = 1'b1;
        cycle();
        bus.serviceDone = 1'b0;
        check("fixed_done_dack", {4'd0, bus.DACK}, 8'd0);
        check("fixed_done_hrq", {7'd0, bus.HRQ}, 8'd0);
        cycle();
        cycle();
        check("fixed_rerequest", {4'd0, bus.DACK}, 8'h02);
        bus.serviceDone = 1'b1;
        cycle();
        bus.serviceDone = 1'b0;
        bus.DREQ = 4'b0000;
        bus.HLDA = 1'b0;
        cycle();
        cycle();

        // Rotating priority from reset, everyone requesting.
        reset_pulse("rst_rot");
        bus.rotatingPriority = 1'b1;
        bus.DREQ = 4'b1111;
        bus.HLDA = 1'b1;
        for (int g = 0; g < 5; g++) begin
            logic [3:0] exp_dack;
            exp_dack = 4'b0001 << (g % 4);
            cycle();
            cycle();
            check("rot_order", {4'd0, bus.DACK}, {4'd0, exp_dack});
            bus.serviceDone = 1'b1;
            cycle();
            bus.serviceDone = 1'b0;
            check("rot_gap_hrq", {7'd0, bus.HRQ}, 8'd0);
        end

        // Serve ch1 so ch2 leads, then lose the bus during the ch2 grant.
        bus.DREQ = 4'b0010;
        cycle();
        cycle();
        check("rot_ch1", {4'd0, bus.DACK}, 8'h02);
        bus.serviceDone = 1'b1;
        cycle();
        bus.serviceDone = 1'b0;
        bus.DREQ = 4'b1111;
        cycle();
        cycle();
        check("loss_pre_dack", {4'd0, bus.DACK}, 8'h04);
        bus.HLDA = 1'b0;
        cycle();
        check("loss_dack", {4'd0, bus.DACK}, 8'd0);
        bus.HLDA = 1'b1;
        cycle();
        cycle();
        check("loss_rewin", {4'd0, bus.DACK}, 8'h04);
        bus.serviceDone = 1'b1;
        cycle();
        bus.serviceDone = 1'b0;
        bus.DREQ = 4'b0000;
        bus.HLDA = 1'b0;
        cycle();

        // Masking.
        bus.rotatingPriority = 1'b0;
        bus.DREQ    = 4'b0001;
        bus.maskReg = 4'b0001;
        cycle();
        cycle();
        check("mask_hrq_low", {7'd0, bus.HRQ}, 8'd0);
        bus.maskReg = 4'b0000;
        cycle();
        check("unmask_hrq", {7'd0, bus.HRQ}, 8'd1);

        // Withdrawal before hold-ack.
        bus.DREQ = 4'b0000;
        cycle();
        check("withdraw_hrq", {7'd0, bus.HRQ}, 8'd0);
        bus.HLDA = 1'b1;
        cycle();
        check("withdraw_dack", {4'd0, bus.DACK}, 8'd0);

        // Asynchronous reset in the middle of a grant.
        bus.DREQ = 4'b0001;
        cycle();
        cycle();
        check("pre_reset_dack", {4'd0, bus.DACK}, 8'h01);
        reset_pulse("rst_mid");
        bus.rotatingPriority = 1'b1;
        bus.DREQ = 4'b1000;
        cycle();
        cycle();
        check("post_reset_ch3", {4'd0, bus.DACK}, 8'h08);
        bus.serviceDone = 1'b1;
        cycle();
        bus.serviceDone = 1'b0;

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            bus.DREQ             = 4'($urandom_range(0, 15));
            bus.maskReg          = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            if ($urandom_range(0, 15) == 0) bus.rotatingPriority = ~bus.rotatingPriority;
            bus.HLDA             = ($urandom_range(0, 7) != 0);
            bus.serviceDone      = ($urandom_range(0, 3) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
